// File: rtl/piso_reader_pkg.sv
// Shared types and constants for the piso_reader block: FSM state encoding,
// default word width and the bit-counter sizing helper.
package piso_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // Counter must reach WIDTH without wrapping, hence WIDTH+1 codes.
    function automatic int cnt_bits(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/piso_shift.sv
// piso_shift: WIDTH-bit load/shift register. The head bit (MSB or LSB,
// selected by MSB_FIRST) is the serial output; the vacated end is filled
// with 'fill' on every shift.
module piso_shift
    import piso_reader_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    input  logic             fill,
    output logic             sout
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next register value: load has priority over shift.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        data_d = data_q;
        if (load) begin
            data_d = load_data;
        end else if (shift_en) begin
            if (MSB_FIRST) data_d = {data_q[WIDTH-2:0], fill};
            else           data_d = {fill, data_q[WIDTH-1:1]};
        end
    end

    // Register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) data_q <= '0;
        else     data_q <= data_d;
    end

    assign sout = MSB_FIRST ? data_q[WIDTH-1] : data_q[0];

endmodule

// File: rtl/piso_reader.sv
// piso_reader: captures a parallel word on START and shifts it out over a
// valid/ready serial link, flagging the final bit with SLAST and pulsing DONE.
// Optional feature macro: PISO_READER_PARITY_EN appends an even-parity bit.
module piso_reader
    import piso_reader_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] R_IN,
    input  logic             START,
    input  logic             SREADY,
    output logic             SOUT,
    output logic             SVALID,
    output logic             SLAST,
    output logic             BUSY,
    output logic             DONE
);

    localparam int CW = cnt_bits(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            svalid_q, svalid_d;
    logic            slast_q, slast_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            sh_load, sh_shift, sh_fill;
    logic [WIDTH-1:0] sh_data;

`ifdef PISO_READER_PARITY_EN
    logic parity_q, parity_d;
    // Once all data bits have shifted out, the head holds the parity fill.
    assign sh_fill = parity_q;
`else
    localparam logic [CW-1:0] PEN_IDX = CW'(WIDTH - 2);
    // Zero fill leaves SOUT low once the word has fully shifted out.
    assign sh_fill = 1'b0;
`endif

    piso_shift #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk       (CLK),
        .rst       (RST),
        .load      (sh_load),
        .load_data (sh_data),
        .shift_en  (sh_shift),
        .fill      (sh_fill),
        .sout      (SOUT)
    );

    // Next state, counter, shifter controls and next registered outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        svalid_d = 1'b0;
        slast_d  = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        sh_data  = R_IN;
`ifdef PISO_READER_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (START) begin
                    state_d  = ST_SHIFT;
                    cnt_d    = '0;
                    sh_load  = 1'b1;
                    svalid_d = 1'b1;
                    busy_d   = 1'b1;
`ifdef PISO_READER_PARITY_EN
                    parity_d = ^R_IN;
`endif
                end
            end
            ST_SHIFT: begin
                svalid_d = 1'b1;
                busy_d   = 1'b1;
                slast_d  = slast_q;
                if (SREADY) begin
                    sh_shift = 1'b1;
                    cnt_d    = cnt_q + CW'(1);
`ifdef PISO_READER_PARITY_EN
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_PARITY;
                        slast_d = 1'b1;
                    end
`else
                    if (cnt_q == LAST_IDX) begin
                        state_d  = ST_DONE;
                        svalid_d = 1'b0;
                        busy_d   = 1'b0;
                        slast_d  = 1'b0;
                        done_d   = 1'b1;
                    end else if (cnt_q == PEN_IDX) begin
                        slast_d = 1'b1;
                    end
`endif
                end
            end
            ST_PARITY: begin
                svalid_d = 1'b1;
                busy_d   = 1'b1;
                slast_d  = 1'b1;
                if (SREADY) begin
                    state_d  = ST_DONE;
                    svalid_d = 1'b0;
                    busy_d   = 1'b0;
                    slast_d  = 1'b0;
                    done_d   = 1'b1;
                    sh_load  = 1'b1;
                    sh_data  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            svalid_q <= 1'b0;
            slast_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef PISO_READER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            svalid_q <= svalid_d;
            slast_q  <= slast_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef PISO_READER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign SVALID = svalid_q;
    assign SLAST  = slast_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;

endmodule
